// File: rtl/ahb_lite_master.sv
// ahb_lite_master
//   AHB-Lite initiator for the USB endpoint register map. Accepts single
//   read/write commands over a valid/ready handshake, issues one NONSEQ
//   transfer per command, handles hready wait states and hresp error
//   termination, and returns exactly one registered response per command.
//
//   Build option: define AHB_MASTER_PIPELINE_EN to let the address phase of
//   the next transfer overlap the data phase of the current one (BOTH state).
//   Left undefined, a command is taken only when the master is fully idle.
//
//   Ports
//     clk, n_rst                 clock, asynchronous active-low reset
//     cmd_valid/cmd_ready        command handshake
//     cmd_write/addr/size/wdata  command payload (size = bytes-1)
//     rsp_valid                  one-cycle pulse per completed command
//     rsp_rdata/rsp_error        masked read data / hresp termination flag
//     busy                       address or data phase outstanding
//     hsel..hwdata               registered AHB-Lite master outputs
//     hrdata, hready, hresp      slave response
module ahb_lite_master (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [3:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        busy,
  output logic        hsel,
  output logic [1:0]  htrans,
  output logic [3:0]  haddr,
  output logic [1:0]  hsize,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // State encodes which slots hold a transfer: ADDR = address slot only,
  // DATA = data slot only, BOTH = pipelined overlap of the two.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_BOTH = 2'd3
  } state_e;

  state_e      state_q, state_d;

  logic        a_wr_q,    a_wr_d;
  logic [3:0]  a_addr_q,  a_addr_d;
  logic [1:0]  a_size_q,  a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;

  logic        d_wr_q,    d_wr_d;
  logic [1:0]  d_size_q,  d_size_d;
  logic [31:0] d_wdata_q, d_wdata_d;

  logic        hsel_q,   hsel_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [3:0]  haddr_q,  haddr_d;
  logic [1:0]  hsize_q,  hsize_d;
  logic        hwrite_q, hwrite_d;
  logic [31:0] hwdata_q, hwdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        a_vld, d_vld;
  logic        a_vld_nxt, d_vld_nxt;
  logic        cmd_acc, addr_acc, data_done;
  logic [31:0] rd_mask;

  assign a_vld = (state_q == S_ADDR) || (state_q == S_BOTH);
  assign d_vld = (state_q == S_DATA) || (state_q == S_BOTH);
  assign busy  = a_vld | d_vld;

  // An address is only taken with hready=1, so an hresp=1/hready=0 error
  // cycle ends the data phase while leaving a pending address for retry.
  assign addr_acc  = a_vld & hready;
  assign data_done = d_vld & (hready | hresp);

`ifdef AHB_MASTER_PIPELINE_EN
  assign cmd_ready = ~a_vld | addr_acc;
`else
  assign cmd_ready = ~busy;
`endif

  assign cmd_acc = cmd_valid & cmd_ready;

  always_comb begin
    unique case (d_size_q)
      2'd0:    rd_mask = 32'h0000_00FF;
      2'd1:    rd_mask = 32'h0000_FFFF;
      2'd2:    rd_mask = 32'h00FF_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    a_wr_d    = a_wr_q;
    a_addr_d  = a_addr_q;
    a_size_d  = a_size_q;
    a_wdata_d = a_wdata_q;
    d_wr_d    = d_wr_q;
    d_size_d  = d_size_q;
    d_wdata_d = d_wdata_q;
    a_vld_nxt = a_vld;
    d_vld_nxt = d_vld;

    if (cmd_acc) begin
      a_vld_nxt = 1'b1;
      a_wr_d    = cmd_write;
      a_addr_d  = cmd_addr;
      a_size_d  = cmd_size;
      a_wdata_d = cmd_wdata;
    end else if (addr_acc) begin
      a_vld_nxt = 1'b0;
    end

    // addr_acc implies hready=1, so any outstanding data phase completes on
    // the same edge and the data slot can simply be overwritten.
    if (addr_acc) begin
      d_vld_nxt = 1'b1;
      d_wr_d    = a_wr_q;
      d_size_d  = a_size_q;
      d_wdata_d = a_wdata_q;
    end else if (data_done) begin
      d_vld_nxt = 1'b0;
    end

    unique case ({a_vld_nxt, d_vld_nxt})
      2'b00:   state_d = S_IDLE;
      2'b10:   state_d = S_ADDR;
      2'b01:   state_d = S_DATA;
      default: state_d = S_BOTH;
    endcase

    // Bus outputs are registered from the next-state slot contents.
    hsel_d   = a_vld_nxt | d_vld_nxt;
    htrans_d = a_vld_nxt ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_d  = a_vld_nxt ? a_addr_d : '0;
    hsize_d  = a_vld_nxt ? a_size_d : '0;
    hwrite_d = a_vld_nxt & a_wr_d;
    hwdata_d = (d_vld_nxt && d_wr_d) ? d_wdata_d : '0;

    rsp_valid_d = data_done;
    rsp_error_d = data_done & hresp;
    rsp_rdata_d = (data_done && !d_wr_q && !hresp) ? (hrdata & rd_mask) : '0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      a_wr_q      <= 1'b0;
      a_addr_q    <= '0;
      a_size_q    <= '0;
      a_wdata_q   <= '0;
      d_wr_q      <= 1'b0;
      d_size_q    <= '0;
      d_wdata_q   <= '0;
      hsel_q      <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hsize_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      a_wr_q      <= a_wr_d;
      a_addr_q    <= a_addr_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_wr_q      <= d_wr_d;
      d_size_q    <= d_size_d;
      d_wdata_q   <= d_wdata_d;
      hsel_q      <= hsel_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hsize_q     <= hsize_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign hsel      = hsel_q;
  assign htrans    = htrans_q;
  assign haddr     = haddr_q;
  assign hsize     = hsize_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
`timescale 1ns/1ps
module tb_ahb_lite_master;

`ifdef AHB_MASTER_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic        clk;
  logic        n_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [3:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic        hsel;
  logic [1:0]  htrans;
  logic [3:0]  haddr;
  logic [1:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  ahb_lite_master dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_error (rsp_error),
    .busy      (busy),
    .hsel      (hsel),
    .htrans    (htrans),
    .haddr     (haddr),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: a read returns the low (size+1) bytes of the slave data.
  function automatic logic [31:0] model_rd(input logic [31:0] d, input logic [1:0] sz);
    logic [63:0] m;
    m = (64'd1 << (8 * (int'(sz) + 1))) - 64'd1;
    return d & m[31:0];
  endfunction

  task automatic drive_cmd(input logic wr, input logic [3:0] a, input logic [1:0] sz,
                           input logic [31:0] wd);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_size  = sz;
    cmd_wdata = wd;
  endtask

  // One isolated transfer: waits = data-phase hready=0 cycles, err = slave
  // terminates with hresp=1/hready=0 after the waits.
  task automatic txn(input logic wr, input logic [3:0] a, input logic [1:0] sz,
                     input logic [31:0] wd, input logic [31:0] rd,
                     input int unsigned waits, input logic err);
    logic [31:0] exp_rd;
    logic [31:0] exp_wd;
    exp_rd = (wr || err) ? 32'd0 : model_rd(rd, sz);
    exp_wd = wr ? wd : 32'd0;
    @(negedge clk);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_hsel", hsel, 0);
    drive_cmd(wr, a, sz, wd);
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = rd;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ap_htrans", htrans, 2);
    chk("ap_hsel", hsel, 1);
    chk("ap_haddr", haddr, a);
    chk("ap_hsize", hsize, sz);
    chk("ap_hwrite", hwrite, wr);
    chk("ap_busy", busy, 1);
    chk("ap_cmd_ready", cmd_ready, PIPE);
    @(negedge clk);
    chk("dp_htrans", htrans, 0);
    chk("dp_hsel", hsel, 1);
    chk("dp_hwdata", hwdata, exp_wd);
    chk("dp_cmd_ready", cmd_ready, PIPE);
    for (int i = 0; i <= int'(waits); i++) begin
      if (i < int'(waits)) begin
        hready = 1'b0; hresp = 1'b0;
      end else if (err) begin
        hready = 1'b0; hresp = 1'b1;
      end else begin
        hready = 1'b1; hresp = 1'b0;
      end
      @(negedge clk);
      if (i < int'(waits)) begin
        chk("wait_hwdata", hwdata, exp_wd);
        chk("wait_hsel", hsel, 1);
        chk("wait_no_rsp", rsp_valid, 0);
      end
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_error", rsp_error, err);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_busy", busy, 0);
    chk("rsp_cmd_ready", cmd_ready, 1);
    hready = 1'b1;
    hresp  = 1'b0;
  endtask

  initial begin
    logic [31:0] rda, rdb, wda;
    n_rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_size = '0; cmd_wdata = '0; hrdata = '0; hready = 1'b1; hresp = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_hsel", hsel, 0);
    chk("rst_htrans", htrans, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    n_rst = 1'b1;

    // Directed cases from the test plan
    txn(1'b1, 4'h0, 2'd3, 32'hDEADBEEF, 32'h0, 0, 1'b0);
    txn(1'b0, 4'h8, 2'd0, 32'h0, 32'h12345678, 0, 1'b0);
    txn(1'b0, 4'h2, 2'd1, 32'h0, 32'h12345678, 3, 1'b0);
    txn(1'b1, 4'h4, 2'd3, 32'hCAFEF00D, 32'h0, 0, 1'b1);
    txn(1'b0, 4'hC, 2'd2, 32'h0, 32'hA1B2C3D4, 1, 1'b1);

    // Two back-to-back commands
    @(negedge clk);
    rda = 32'h89ABCDEF; rdb = 32'h13572468; wda = 32'h0BADF00D;
`ifdef AHB_MASTER_PIPELINE_EN
    drive_cmd(1'b1, 4'h1, 2'd3, wda);
    chk("p2_cmd_ready0", cmd_ready, 1);
    @(negedge clk);
    chk("p2_htrans_a", htrans, 2);
    chk("p2_haddr_a", haddr, 4'h1);
    chk("p2_cmd_ready1", cmd_ready, 1);
    drive_cmd(1'b0, 4'h6, 2'd1, 32'h0);
    hrdata = rdb;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("p2_htrans_b", htrans, 2);
    chk("p2_haddr_b", haddr, 4'h6);
    chk("p2_hwdata_a", hwdata, wda);
    @(negedge clk);
    chk("p2_rsp_a_valid", rsp_valid, 1);
    chk("p2_rsp_a_rdata", rsp_rdata, 0);
    chk("p2_htrans_idle", htrans, 0);
    @(negedge clk);
    chk("p2_rsp_b_valid", rsp_valid, 1);
    chk("p2_rsp_b_rdata", rsp_rdata, model_rd(rdb, 2'd1));
    @(negedge clk);
    chk("p2_rsp_end", rsp_valid, 0);
    chk("p2_busy_end", busy, 0);

    // Error on transfer k while k+1 waits in its address phase
    drive_cmd(1'b1, 4'h4, 2'd3, wda);
    @(negedge clk);
    drive_cmd(1'b0, 4'h9, 2'd2, 32'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("pe_haddr_b", haddr, 4'h9);
    hresp = 1'b1; hready = 1'b0;
    @(negedge clk);
    chk("pe_rsp_valid", rsp_valid, 1);
    chk("pe_rsp_error", rsp_error, 1);
    chk("pe_rsp_rdata", rsp_rdata, 0);
    chk("pe_retry_htrans", htrans, 2);
    chk("pe_retry_haddr", haddr, 4'h9);
    hresp = 1'b0; hready = 1'b1; hrdata = rda;
    @(negedge clk);
    chk("pe_b_dp_htrans", htrans, 0);
    chk("pe_b_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("pe_b_rsp_valid", rsp_valid, 1);
    chk("pe_b_rsp_error", rsp_error, 0);
    chk("pe_b_rsp_rdata", rsp_rdata, model_rd(rda, 2'd2));
`else
    drive_cmd(1'b0, 4'h1, 2'd3, 32'h0);
    hrdata = rda;
    chk("n2_cmd_ready0", cmd_ready, 1);
    @(negedge clk);
    drive_cmd(1'b1, 4'h5, 2'd1, wda);
    chk("n2_cmd_ready1", cmd_ready, 0);
    chk("n2_htrans_a", htrans, 2);
    chk("n2_haddr_a", haddr, 4'h1);
    @(negedge clk);
    chk("n2_cmd_ready2", cmd_ready, 0);
    chk("n2_htrans_dp", htrans, 0);
    @(negedge clk);
    chk("n2_rsp_a_valid", rsp_valid, 1);
    chk("n2_rsp_a_rdata", rsp_rdata, rda);
    chk("n2_gap_htrans", htrans, 0);
    chk("n2_cmd_ready3", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("n2_htrans_b", htrans, 2);
    chk("n2_haddr_b", haddr, 4'h5);
    chk("n2_hwrite_b", hwrite, 1);
    @(negedge clk);
    chk("n2_hwdata_b", hwdata, wda);
    @(negedge clk);
    chk("n2_rsp_b_valid", rsp_valid, 1);
    chk("n2_rsp_b_rdata", rsp_rdata, 0);
`endif

    // Reset while a data phase is stalled
    @(negedge clk);
    drive_cmd(1'b1, 4'h3, 2'd3, 32'h55AA55AA);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    hready = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk("mr_hsel", hsel, 0);
    chk("mr_htrans", htrans, 0);
    chk("mr_haddr", haddr, 0);
    chk("mr_hwrite", hwrite, 0);
    chk("mr_hwdata", hwdata, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    n_rst = 1'b1; hready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mr_no_rsp", rsp_valid, 0);
    end

    // Randomized isolated transfers
    for (int k = 0; k < 30; k++) begin
      txn(1'($urandom), 4'($urandom), 2'($urandom), $urandom, $urandom,
          $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
